process_scheduler: RTL and testbench
====================================

# process_scheduler

Parametrised process control block with a round-robin scheduler for the CPU. It holds a saved-PC table for `NPROC` process slots and a ready mask. A quantum counter preempts the running process. On quantum expiry, `Yield` or `Kill` it saves the CPU PC and selects the next ready PID, then presents that PID and its restore PC to the CPU with a one-cycle `Switch` strobe. It sits between the processor (`PC_CPU`, `PID_CPU` consumers) and the BIOS/MMU. It replaces the fixed single-table PCB with configurable depth, widths and time slicing.

## Interface
- `NPROC`, 8: number of process slots, 2..32.
- `PID_W`, 5: PID width; must satisfy 2^PID_W >= NPROC.
- `PC_W`, 32: program-counter width.
- `QUANTUM`, 64: enabled cycles per time slice, >= 1.

- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Enable` in 1: quantum counter advances only when high.
- `Create` in 1: register process `CreatePID` with entry PC `CreatePC`.
- `CreatePID` in PID_W: slot to create.
- `CreatePC` in PC_W: entry PC for the created slot.
- `Yield` in 1: running process gives up the CPU.
- `Kill` in 1: running process terminates.
- `PC_CPU` in PC_W: current CPU PC, saved on a switch.
- `PID_out` out PID_W: running PID.
- `PC_PID` out PC_W: restore PC for `PID_out`.
- `Switch` out 1: one-cycle pulse; CPU loads `PC_PID`.
- `Idle` out 1: no process running.
- `ReadyMask` out NPROC: ready bit per slot.
- `CreateErr` out 1: one-cycle pulse when a `Create` is rejected.

## Operation
- States: `IDLE`, `RUN`, `SAVE`, `SELECT`, `LOAD`.
- `IDLE`
  - `Idle`=1.
  - If `ReadyMask` != 0, go to `SELECT`.
- `RUN`
  - When `Enable` is high, the quantum counter decrements.
  - The counter reaching 0 with `Enable` high, or `Yield`, or `Kill`, moves the FSM to `SAVE`.
  - `Kill` has priority over `Yield`; coincident events cause a single switch.
- `SAVE` (1 cycle)
  - Normally `table[PID_out]` <= `PC_CPU`.
  - If the trigger was `Kill`, the PC is not saved; instead `ready[PID_out]` <= 0.
  - Next state is `SELECT`.
- `SELECT` (1 cycle)
  - Round-robin search over the registered `ReadyMask`, in order PID_out+1, …, NPROC-1, 0, …, PID_out.
  - The current slot is checked last, so a sole ready process is re-selected.
  - Found: latch the result as `next`, go to `LOAD`. None found: go to `IDLE`.
- `LOAD`
  - `PID_out` <= `next`, `PC_PID` <= `table[next]`.
  - Quantum counter <= QUANTUM-1.
  - `Switch` is asserted for the following cycle; next state is `RUN`.
- `Create` (accepted in any state)
  - Sets `ready[CreatePID]` and writes `table[CreatePID]` <= `CreatePC`.
  - Rejected, with a `CreateErr` pulse and no state change, when `CreatePID` >= NPROC.
  - Also rejected when `CreatePID` == `PID_out` and the state is not `IDLE`.
  - Takes effect at the clock edge; `SELECT` sees it from the next cycle.
  - A `Create` in the same cycle as `SAVE` to a different slot proceeds independently.
- `Yield`/`Kill` outside `RUN` are ignored.
- `Enable` low freezes only the counter.

## Timing
- Reset values:
  - `PID_out`=0, `PC_PID`=0, `Switch`=0, `Idle`=1, `ReadyMask`=0, `CreateErr`=0.
  - Table entries 0, counter 0, state `IDLE`.
- Event latency: a trigger sampled at edge E0 produces:
  - E1: PC saved.
  - E2: selection.
  - E3: `PID_out`/`PC_PID` updated.
  - `Switch` high during the cycle following E3.
- The preempted CPU keeps executing between E0 and E3; the CPU holds its PC while `Switch` is pending.
- Time slice: exactly QUANTUM enabled cycles from the `LOAD` edge to the expiry sample.
- From `IDLE`, a first `Create` at edge C gives `Switch` high after C+3.
- All outputs are registered.
- `Reset` asserted mid-switch aborts immediately to reset values; no partial table write is required to survive.

## Configuration
- `SCHED_PRIORITY_EN`
  - Defined: `SELECT` picks the lowest-index ready slot, which is fixed priority; the quantum still preempts, and a higher-priority process regains the CPU at each slice end.
  - Undefined: round-robin as above.

## Test plan
- Reset, then `Create` PID 2 at PC 0x100 → `Switch` pulse 3 cycles later, `PID_out`=2, `PC_PID`=0x100, `Idle`=0.
- PIDs 1,2,3 created, QUANTUM=4, `Enable`=1, `PC_CPU` tracking → switches every 4 RUN cycles plus 3 in order 1,2,3,1; restored PC equals the PC saved at each process's last `SAVE`.
- Running PID 3 asserts `Kill` together with `Yield`, with PID 1 ready → `ReadyMask[3]`=0, next `PID_out`=1; killing the last ready process → `Idle`=1.
- `Create` with PID 9 (NPROC=8), then `Create` of the running PID → `CreateErr` pulses twice; `ReadyMask` and table unchanged.
- Only PID 0 ready, `Yield` at PC 0x40 → `Switch` with `PID_out`=0, `PC_PID`=0x40; `Enable`=0 for 10 cycles → no preemption.
- With `SCHED_PRIORITY_EN`, PIDs 4 and 1 ready, PID 4 running → next selection is 1, and remains 1 at every slice end.

Source files
------------

// File: rtl/process_scheduler.sv
// process_scheduler: saved-PC table, ready mask and quantum-driven scheduler that switches the CPU
// between process slots. Define SCHED_PRIORITY_EN for fixed-priority (lowest index) selection.

module process_scheduler #(
    parameter int NPROC   = 8,
    parameter int PID_W   = 5,
    parameter int PC_W    = 32,
    parameter int QUANTUM = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Create,
    input  logic [PID_W-1:0] CreatePID,
    input  logic [PC_W-1:0]  CreatePC,
    input  logic             Yield,
    input  logic             Kill,
    input  logic [PC_W-1:0]  PC_CPU,
    output logic [PID_W-1:0] PID_out,
    output logic [PC_W-1:0]  PC_PID,
    output logic             Switch,
    output logic             Idle,
    output logic [NPROC-1:0] ReadyMask,
    output logic             CreateErr,
    output logic [2:0]       state_dbg_o
);

    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [PID_W:0] NPROC_L = (PID_W + 1)'(NPROC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SAVE   = 3'd2,
        ST_SELECT = 3'd3,
        ST_LOAD   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PID_W-1:0]  pid_q, pid_d;
    logic [PID_W-1:0]  next_q, next_d;
    logic [PC_W-1:0]   pc_pid_q, pc_pid_d;
    logic              switch_q, switch_d;
    logic              idle_q, idle_d;
    logic              err_q, err_d;
    logic              kill_q, kill_d;
    logic [QW-1:0]     cnt_q, cnt_d;
    logic [NPROC-1:0]  ready_q, ready_d;
    logic [PC_W-1:0]   table_q [NPROC];
    logic [PC_W-1:0]   table_d [NPROC];

    logic              create_ok;
    logic [NPROC-1:0]  rot;
    int                base;
    int                off;
    logic              sel_found;
    logic [PID_W-1:0]  sel_pid;
    logic [PC_W-1:0]   load_pc;

    // The running slot cannot be overwritten while it owns (or is handing over) the CPU.
    assign create_ok = Create && ({1'b0, CreatePID} < NPROC_L)
                     && !((CreatePID == pid_q) && (state_q != ST_IDLE));
    assign err_d = Create && !create_ok;

    always_comb begin
        table_d = table_q;
        ready_d = ready_q;
        for (int i = 0; i < NPROC; i++) begin
            if (state_q == ST_SAVE && pid_q == PID_W'(i)) begin
                if (kill_q) ready_d[i] = 1'b0;
                else        table_d[i] = PC_CPU;
            end
            if (create_ok && CreatePID == PID_W'(i)) begin
                ready_d[i] = 1'b1;
                table_d[i] = CreatePC;
            end
        end
    end

    // Rotate the mask so bit 0 is the first candidate; the current slot ends up last.
    always_comb begin
`ifdef SCHED_PRIORITY_EN
        base = 0;
`else
        base = int'(pid_q) + 1;
`endif
        rot       = NPROC'({ready_q, ready_q} >> base);
        off       = 0;
        sel_found = 1'b0;
        for (int j = NPROC - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sel_found = 1'b1;
                off       = j;
            end
        end
        sel_pid = PID_W'((base + off) % NPROC);
    end

    // Reading the next-state table forwards a Create that lands on the LOAD edge.
    always_comb begin
        load_pc = '0;
        for (int i = 0; i < NPROC; i++) begin
            if (next_q == PID_W'(i)) load_pc = table_d[i];
        end
    end

    // Switch is a one-cycle strobe with no back-pressure: the CPU loads PC_PID in that cycle.
    always_comb begin
        state_d  = state_q;
        pid_d    = pid_q;
        next_d   = next_q;
        pc_pid_d = pc_pid_q;
        kill_d   = kill_q;
        cnt_d    = cnt_q;
        switch_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q != '0) state_d = ST_SELECT;
            end
            ST_RUN: begin
                if (Enable && cnt_q != '0) cnt_d = cnt_q - QW'(1);
                if (Kill) begin
                    state_d = ST_SAVE;
                    kill_d  = 1'b1;
                end else if (Yield || (Enable && cnt_q == '0)) begin
                    state_d = ST_SAVE;
                    kill_d  = 1'b0;
                end
            end
            ST_SAVE: begin
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (sel_found) begin
                    next_d  = sel_pid;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                pid_d    = next_q;
                pc_pid_d = load_pc;
                cnt_d    = QW'(QUANTUM - 1);
                switch_d = 1'b1;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pid_q    <= '0;
            next_q   <= '0;
            pc_pid_q <= '0;
            switch_q <= 1'b0;
            idle_q   <= 1'b1;
            err_q    <= 1'b0;
            kill_q   <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= '0;
            for (int i = 0; i < NPROC; i++) table_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pid_q    <= pid_d;
            next_q   <= next_d;
            pc_pid_q <= pc_pid_d;
            switch_q <= switch_d;
            idle_q   <= idle_d;
            err_q    <= err_d;
            kill_q   <= kill_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            table_q  <= table_d;
        end
    end

    assign PID_out     = pid_q;
    assign PC_PID      = pc_pid_q;
    assign Switch      = switch_q;
    assign Idle        = idle_q;
    assign ReadyMask   = ready_q;
    assign CreateErr   = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: randomized slices checked against an event-level scheduler model;
// expected switches are queued and matched by an independent monitor.

module tb_process_scheduler;

    localparam int NPROC   = 8;
    localparam int PID_W   = 5;
    localparam int PC_W    = 32;
    localparam int QUANTUM = 4;
    localparam int EW      = 32 + PID_W + PC_W;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             Enable = 1'b0;
    logic             Create = 1'b0;
    logic [PID_W-1:0] CreatePID = '0;
    logic [PC_W-1:0]  CreatePC = '0;
    logic             Yield = 1'b0;
    logic             Kill = 1'b0;
    logic [PC_W-1:0]  PC_CPU = '0;
    logic [PID_W-1:0] PID_out;
    logic [PC_W-1:0]  PC_PID;
    logic             Switch;
    logic             Idle;
    logic [NPROC-1:0] ReadyMask;
    logic             CreateErr;
    logic [2:0]       state_dbg;

    process_scheduler #(
        .NPROC(NPROC), .PID_W(PID_W), .PC_W(PC_W), .QUANTUM(QUANTUM)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Create(Create),
        .CreatePID(CreatePID), .CreatePC(CreatePC), .Yield(Yield), .Kill(Kill),
        .PC_CPU(PC_CPU), .PID_out(PID_out), .PC_PID(PC_PID), .Switch(Switch),
        .Idle(Idle), .ReadyMask(ReadyMask), .CreateErr(CreateErr),
        .state_dbg_o(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        int              pid;
        logic [PC_W-1:0] pc;
    } cr_t;

    logic [NPROC-1:0] m_ready = '0;
    logic [PC_W-1:0]  m_table [NPROC];
    int               m_pid = 0;
    bit               m_idle = 1'b1;
    bit               exp_err = 1'b0;
    cr_t              cr_q[$];

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Next process by the scheduling rule: scan slots after the running one, wrapping round.
    function automatic int pick();
`ifdef SCHED_PRIORITY_EN
        for (int s = 0; s < NPROC; s++) if (m_ready[s]) return s;
`else
        for (int i = 1; i <= NPROC; i++) begin
            int s;
            s = (m_pid + i) % NPROC;
            if (m_ready[s]) return s;
        end
`endif
        return -1;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge: checks outputs, drives the inputs for the next rising edge.
    task automatic drive_cycle(input bit en, input bit yld, input bit kil, input bit cr,
                               input int cpid, input logic [PC_W-1:0] cpc,
                               input logic [PC_W-1:0] pc, input int sv);
        check("ready_mask", 64'(ReadyMask), 64'(m_ready));
        check("create_err", 64'(CreateErr), 64'(exp_err));
        check("idle", 64'(Idle), 64'(m_idle));
        check("pid_out", 64'(PID_out), 64'(m_pid));
        Enable    = en;
        Yield     = yld;
        Kill      = kil;
        Create    = cr;
        CreatePID = PID_W'(cpid);
        CreatePC  = cpc;
        PC_CPU    = pc;
        if (sv == 1) m_table[m_pid] = pc;
        else if (sv == 2) m_ready[m_pid] = 1'b0;
        exp_err = 1'b0;
        if (cr) begin
            if (cpid >= NPROC || (cpid == m_pid && !m_idle)) exp_err = 1'b1;
            else begin
                m_ready[cpid] = 1'b1;
                m_table[cpid] = cpc;
            end
        end
        @(negedge Clock);
    endtask

    task automatic quiet_cycle();
        drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, 0, '0, $urandom, 0);
    endtask

    // Entered at the falling edge after the LOAD edge; returns at the one after the next LOAD edge
    // (or after the failed selection, with m_idle set).
    task automatic run_slice(input int action, input int k, input int en_pct, input int hold_off,
                             input bit rnd_cr, input bit force_pc, input logic [PC_W-1:0] save_pc);
        int left, t, e0, nxt, cpid;
        bit trig, killed, en, yld, kil, cr;
        logic [PC_W-1:0] cpc, pc;
        cr_t c;
        left = QUANTUM; t = 0; trig = 1'b0; killed = 1'b0;
        while (!trig) begin
            en  = (t >= hold_off) && ($urandom_range(1, 100) <= en_pct);
            if (t > 200) en = 1'b1;
            yld = (action == 1 || action == 3) && (t == k);
            kil = (action >= 2) && (t == k);
            cr = 1'b0; cpid = 0; cpc = '0;
            if (cr_q.size() > 0) begin
                c = cr_q.pop_front();
                cr = 1'b1; cpid = c.pid; cpc = c.pc;
            end else if (rnd_cr && $urandom_range(0, 3) == 0) begin
                cr = 1'b1; cpid = $urandom_range(0, 9); cpc = $urandom;
            end
            trig = yld || kil || (en && left == 1);
            if (en && left > 1) left--;
            killed = kil;
            drive_cycle(en, yld, kil, cr, cpid, cpc, $urandom, 0);
            t++;
        end
        e0 = cyc;
        cr = rnd_cr && ($urandom_range(0, 3) == 0);
        cpid = $urandom_range(0, 9);
        pc = force_pc ? save_pc : $urandom;
        drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    cr, cpid, $urandom, pc, killed ? 2 : 1);
        nxt = pick();
        quiet_cycle();
        if (nxt < 0) begin
            m_idle = 1'b1;
            return;
        end
        exp_q.push_back({32'(e0 + 3), PID_W'(nxt), m_table[nxt]});
        quiet_cycle();
        m_pid = nxt;
    endtask

    // Entered while idle: optional rejected Create, then a Create of pid; returns after its LOAD edge.
    task automatic idle_phase(input int pid, input logic [PC_W-1:0] pc, input bit bad_first);
        int c_edge;
        repeat ($urandom_range(1, 3)) quiet_cycle();
        if (bad_first)
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, $urandom_range(NPROC, 31), $urandom, $urandom, 0);
        c_edge = cyc + 1;
        exp_q.push_back({32'(c_edge + 3), PID_W'(pid), pc});
        drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, pid, pc,
                    $urandom, 0);
        quiet_cycle();
        m_idle = 1'b0;
        quiet_cycle();
        quiet_cycle();
        m_pid = pid;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] mon_e;
    always @(negedge Clock) begin
        if (!Reset && Switch) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_switch pid=%0d pc=%0h (cycle %0d) required no switch",
                         PID_out, PC_PID, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("switch_cycle", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
                check("switch_pid", 64'(PID_out), 64'(mon_e[PC_W +: PID_W]));
                check("switch_pc", 64'(PC_PID), 64'(mon_e[PC_W-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NPROC; i++) m_table[i] = '0;
        repeat (2) @(negedge Clock);
        check("rst_pid", 64'(PID_out), 64'd0);
        check("rst_pc", 64'(PC_PID), 64'd0);
        check("rst_switch", 64'(Switch), 64'd0);
        check("rst_idle", 64'(Idle), 64'd1);
        check("rst_ready", 64'(ReadyMask), 64'd0);
        check("rst_err", 64'(CreateErr), 64'd0);
        Reset = 1'b0;

        idle_phase(2, 32'h100, 1'b0);
        run_slice(2, 1, 100, 0, 1'b0, 1'b0, '0);

        idle_phase(1, 32'h10, 1'b1);
        cr_q.push_back('{pid: 2, pc: 32'h20});
        cr_q.push_back('{pid: 3, pc: 32'h30});
        repeat (5) run_slice(0, 99, 100, 0, 1'b0, 1'b0, '0);
        run_slice(3, 2, 100, 0, 1'b0, 1'b0, '0);

        cr_q.push_back('{pid: 9, pc: 32'hdead});
        cr_q.push_back('{pid: m_pid, pc: 32'hbeef});
        run_slice(0, 99, 100, 0, 1'b0, 1'b0, '0);

        run_slice(2, 0, 100, 0, 1'b0, 1'b0, '0);
        run_slice(2, 0, 100, 0, 1'b0, 1'b0, '0);
        idle_phase(0, $urandom, 1'b0);
        run_slice(1, 2, 100, 0, 1'b0, 1'b1, 32'h40);
        run_slice(0, 99, 100, 10, 1'b0, 1'b0, '0);

        run_slice(2, 0, 100, 0, 1'b0, 1'b0, '0);
        idle_phase(4, $urandom, 1'b0);
        cr_q.push_back('{pid: 1, pc: 32'h1000});
        repeat (3) run_slice(0, 99, 100, 0, 1'b0, 1'b0, '0);

        repeat (40) begin
            if (m_idle) idle_phase($urandom_range(0, NPROC - 1), $urandom, 1'($urandom_range(0, 1)));
            else run_slice($urandom_range(0, 3), $urandom_range(0, 6), 75, 0, 1'b1, 1'b0, '0);
        end

        repeat (6) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, '0, $urandom, 0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
